// File: rtl/nios_sqrt_pkg.sv
// Shared constants and types for the Nios II square-root coprocessor.
package nios_sqrt_pkg;

  localparam logic [1:0] ADDR_OPERAND = 2'd0;
  localparam logic [1:0] ADDR_RESULT  = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_CONTROL = 2'd3;

  localparam int unsigned BUSY_B   = 0;
  localparam int unsigned DONE_B   = 1;
  localparam int unsigned ERR_B    = 2;
  localparam int unsigned IRQ_EN_B = 0;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FINISH
  } state_t;

endpackage

// File: rtl/nios_system_sqrt_ctrl_if.sv
// Avalon-MM slave bus plus interrupt line for the square-root coprocessor.
interface nios_system_sqrt_ctrl_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport slave (
    input  address, chipselect, read, write, writedata,
    output readdata, irq
  );

  modport master (
    output address, chipselect, read, write, writedata,
    input  readdata, irq
  );

endinterface

// File: rtl/nios_sqrt_step.sv
// One restoring square-root iteration: consumes two operand bits, yields one root bit.
module nios_sqrt_step #(
  parameter int unsigned RES_W = 16
) (
  input  logic [RES_W+1:0] rem,
  input  logic [RES_W-1:0] root,
  input  logic [1:0]       bits,
  output logic [RES_W+1:0] rem_nxt,
  output logic [RES_W-1:0] root_nxt
);

  localparam int unsigned REM_W = RES_W + 2;

  logic [REM_W-1:0] rem_sh;
  logic [REM_W-1:0] trial;
  logic             ge;

  always_comb begin
    rem_sh   = (rem << 2) | REM_W'(bits);
    trial    = {root, 2'b01};
    ge       = (rem_sh >= trial);
    rem_nxt  = ge ? (rem_sh - trial) : rem_sh;
    root_nxt = {root[RES_W-2:0], ge};
  end

endmodule

// File: rtl/nios_system_sqrt_ctrl.sv
// Register map, sequencing FSM and interrupt for the iterative square-root coprocessor.
module nios_system_sqrt_ctrl
  import nios_sqrt_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  nios_system_sqrt_ctrl_if.slave bus
);

  localparam int unsigned RES_W = DATA_W / 2;
  localparam int unsigned CNT_W = $clog2(RES_W);
  localparam int unsigned REM_W = RES_W + 2;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   operand;
  logic [DATA_W-1:0]   shreg;
  logic [RES_W-1:0]    root, root_nxt, result;
  logic [REM_W-1:0]    rem, rem_nxt;
  logic [CNT_W-1:0]    cnt;
  logic                busy, done, err, irq_en;
  logic [31:0]         readdata, rd_mux;

  logic wr_sel, rd_sel, op_wr, op_busy_wr, stat_wr, ctl_wr;
  logic start, iter, fin, last_iter;

  assign wr_sel     = bus.chipselect & bus.write;
  assign rd_sel     = bus.chipselect & bus.read;
  assign op_wr      = wr_sel && (bus.address == ADDR_OPERAND);
  assign op_busy_wr = op_wr && (state != IDLE);
  assign stat_wr    = wr_sel && (bus.address == ADDR_STATUS);
  assign ctl_wr     = wr_sel && (bus.address == ADDR_CONTROL);
  assign last_iter  = (cnt == CNT_W'(RES_W - 1));

  nios_sqrt_step #(.RES_W(RES_W)) u_step (
    .rem      (rem),
    .root     (root),
    .bits     (shreg[DATA_W-1 -: 2]),
    .rem_nxt  (rem_nxt),
    .root_nxt (root_nxt)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and per-cycle datapath strobes
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    iter      = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: begin
        if (op_wr) begin
          start     = 1'b1;
          state_nxt = ITER;
        end
      end
      ITER: begin
        iter = 1'b1;
        if (last_iter) state_nxt = FINISH;
      end
      FINISH: begin
        fin       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_OPERAND: rd_mux = 32'(operand);
      ADDR_RESULT:  rd_mux = 32'(result);
      ADDR_STATUS: begin
        rd_mux[BUSY_B] = busy;
        rd_mux[DONE_B] = done;
        rd_mux[ERR_B]  = err;
      end
      ADDR_CONTROL: rd_mux[IRQ_EN_B] = irq_en;
      default:      rd_mux = '0;
    endcase
  end

  // Set of done/err takes priority over a same-cycle W1C
  always_ff @(posedge clock) begin
    if (reset) begin
      operand  <= '0;
      shreg    <= '0;
      root     <= '0;
      rem      <= '0;
      cnt      <= '0;
      result   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      irq_en   <= 1'b0;
      readdata <= '0;
    end else begin
      if (start) begin
        operand <= bus.writedata[DATA_W-1:0];
        shreg   <= bus.writedata[DATA_W-1:0];
        root    <= '0;
        rem     <= '0;
        cnt     <= '0;
        busy    <= 1'b1;
      end
      if (iter) begin
        shreg <= shreg << 2;
        root  <= root_nxt;
        rem   <= rem_nxt;
        if (!last_iter) cnt <= cnt + CNT_W'(1);
      end
      if (fin) begin
        result <= root;
        busy   <= 1'b0;
      end
      if (fin)                                         done <= 1'b1;
      else if (start || (stat_wr && bus.writedata[DONE_B])) done <= 1'b0;
      if (op_busy_wr)                                  err <= 1'b1;
      else if (stat_wr && bus.writedata[ERR_B])        err <= 1'b0;
      if (ctl_wr) irq_en <= bus.writedata[IRQ_EN_B];
      if (rd_sel) readdata <= rd_mux;
    end
  end

  assign bus.readdata = readdata;
  assign bus.irq      = done & irq_en;

endmodule

// File: tb/tb_nios_system_sqrt_ctrl.sv
// Directed bench for the square-root coprocessor with a transaction-level reference model.
module tb_nios_system_sqrt_ctrl;

  localparam int LAT = 17;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic model_on = 1'b0;

  nios_system_sqrt_ctrl_if bus ();

  nios_system_sqrt_ctrl #(.DATA_W(32)) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] isqrt(input logic [31:0] v);
    longint r;
    longint x;
    x = longint'(v);
    r = longint'($sqrt(real'(x)));
    while (r * r > x) r--;
    while ((r + 1) * (r + 1) <= x) r++;
    return 32'(r);
  endfunction

  // Reference model: an operation lasts LAT edges, then result and done appear
  logic [31:0] m_operand = '0, m_result = '0, m_pend = '0, m_rd = '0;
  logic        m_done = 1'b0, m_err = 1'b0, m_irq_en = 1'b0;
  int          m_left = 0;

  always @(posedge clk) begin : model_b
    logic ob, fin, wr, start;
    ob    = (m_left != 0);
    fin   = (m_left == 1);
    wr    = bus.chipselect && bus.write;
    start = wr && bus.address == 2'd0 && !ob;
    if (reset) begin
      m_operand <= '0; m_result <= '0; m_pend <= '0; m_rd <= '0;
      m_done <= 1'b0; m_err <= 1'b0; m_irq_en <= 1'b0; m_left <= 0;
    end else begin
      if (bus.chipselect && bus.read) begin
        case (bus.address)
          2'd0: m_rd <= m_operand;
          2'd1: m_rd <= m_result;
          2'd2: m_rd <= {29'd0, m_err, m_done, ob};
          default: m_rd <= {31'd0, m_irq_en};
        endcase
      end
      if (start) begin
        m_operand <= bus.writedata;
        m_pend    <= isqrt(bus.writedata);
        m_left    <= LAT;
      end else if (ob) m_left <= m_left - 1;
      if (fin) m_result <= m_pend;
      if (fin) m_done <= 1'b1;
      else if (start || (wr && bus.address == 2'd2 && bus.writedata[1])) m_done <= 1'b0;
      if (wr && bus.address == 2'd0 && ob) m_err <= 1'b1;
      else if (wr && bus.address == 2'd2 && bus.writedata[2]) m_err <= 1'b0;
      if (wr && bus.address == 2'd3) m_irq_en <= bus.writedata[0];
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("irq_model", 32'(bus.irq), 32'(m_done & m_irq_en));
      chk("readdata_model", bus.readdata, m_rd);
    end
  end

  task automatic op(input logic rd, input logic wr, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.chipselect = 1'b1;
    bus.read       = rd;
    bus.write      = wr;
    bus.address    = a;
    bus.writedata  = d;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    op(1'b0, 1'b1, a, d);
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
    op(1'b1, 1'b0, a, 32'd0);
    d = bus.readdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Poll STATUS until done, bounded; returns number of reads that saw busy
  task automatic poll_done(input string name, output int busy_reads);
    logic [31:0] s;
    bit seen;
    busy_reads = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      rd_reg(2'd2, s);
      if (s[1]) seen = 1'b1;
      else if (s[0]) busy_reads++;
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  logic [31:0] ops  [5] = '{32'd0, 32'd1, 32'd2, 32'hFFFF_FFFF, 32'h3FFF_FFFF};
  logic [31:0] roots[5] = '{32'd0, 32'd1, 32'd1, 32'h0000_FFFF, 32'h0000_7FFF};

  initial begin
    logic [31:0] r;
    logic [31:0] v;
    int nb;
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.address    = 2'd0;
    bus.writedata  = 32'd0;
    model_on       = 1'b1;
    idle(2);
    reset = 1'b0;

    // Reset state
    chk("rst_irq", 32'(bus.irq), 32'd0);
    chk("rst_readdata", bus.readdata, 32'd0);
    for (int a = 0; a < 4; a++) begin
      rd_reg(2'(a), r);
      chk("rst_reg", r, 32'd0);
    end

    // 1: sqrt(144), latency and no irq
    wr_reg(2'd0, 32'd144);
    poll_done("t1", nb);
    chk("t1_busy_reads", 32'(nb), 32'd17);
    rd_reg(2'd1, r);
    chk("t1_result", r, 32'd12);
    chk("t1_irq", 32'(bus.irq), 32'd0);

    // 2: corner operands and a random sweep
    for (int i = 0; i < 5; i++) begin
      wr_reg(2'd0, ops[i]);
      idle(LAT);
      rd_reg(2'd1, r);
      chk("t2_corner", r, roots[i]);
    end
    for (int i = 0; i < 16; i++) begin
      v = (i < 4) ? 32'((i + 300) * (i + 300)) : $urandom;
      wr_reg(2'd0, v);
      idle(LAT);
      rd_reg(2'd1, r);
      chk("t2_random", r, isqrt(v));
    end

    // 3: write while busy is dropped and flags err
    wr_reg(2'd0, 32'd100);
    idle(4);
    wr_reg(2'd0, 32'd49);
    idle(12);
    rd_reg(2'd1, r);
    chk("t3_result", r, 32'd10);
    rd_reg(2'd0, r);
    chk("t3_operand", r, 32'd100);
    rd_reg(2'd2, r);
    chk("t3_status", r, 32'd6);
    wr_reg(2'd2, 32'd4);
    rd_reg(2'd2, r);
    chk("t3_err_cleared", r, 32'd2);

    // 4: irq with done; W1C in the FINISH cycle loses to the set
    wr_reg(2'd3, 32'd1);
    wr_reg(2'd0, 32'd81);
    idle(16);
    chk("t4_irq_before", 32'(bus.irq), 32'd0);
    wr_reg(2'd2, 32'd2);
    chk("t4_irq_after_finish", 32'(bus.irq), 32'd1);
    rd_reg(2'd2, r);
    chk("t4_done_kept", r, 32'd2);
    rd_reg(2'd1, r);
    chk("t4_result", r, 32'd9);
    wr_reg(2'd2, 32'd2);
    chk("t4_irq_cleared", 32'(bus.irq), 32'd0);
    rd_reg(2'd2, r);
    chk("t4_status_cleared", r, 32'd0);

    // 5: reset mid-computation aborts, then a normal operation
    wr_reg(2'd0, 32'd1000);
    idle(7);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("t5_irq", 32'(bus.irq), 32'd0);
    for (int a = 0; a < 4; a++) begin
      rd_reg(2'(a), r);
      chk("t5_reg_zero", r, 32'd0);
    end
    idle(20);
    rd_reg(2'd2, r);
    chk("t5_no_done", r, 32'd0);
    wr_reg(2'd0, 32'd25);
    poll_done("t5", nb);
    chk("t5_busy_reads", 32'(nb), 32'd17);
    rd_reg(2'd1, r);
    chk("t5_result", r, 32'd5);

    idle(2);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
